// File: rtl/blink_led_top.sv
// Heartbeat blinker: divides USER_CLK to a BLINK_HZ square wave on an active-low LED.
// All state is reset synchronously by FPGA_CPU_RESET_B.
module blink_led_top #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BLINK_HZ    = 1
) (
  input  logic USER_CLK,
  input  logic FPGA_CPU_RESET_B,
  output logic GPIO_LED_N
);

  // BLINK_HZ of zero would divide by zero, so fall back to a legal value
  // and let the elaboration check below report it.
  localparam int HALF_PERIOD = (BLINK_HZ > 0) ? CLK_FREQ_HZ / (2 * BLINK_HZ) : 2;
  localparam int CNT_W       = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(HALF_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  if (HALF_PERIOD < 2) begin : g_bad_half_period
    $error("blink_led_top: HALF_PERIOD must be at least 2");
  end
  if (BLINK_HZ <= 0) begin : g_bad_blink_hz
    $error("blink_led_top: BLINK_HZ must be positive");
  end

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             tick_s;
  logic             led_on_r;
  logic             led_on_nxt_s;
  logic             led_n_r;

  // Prescaler wrap detection and LED toggle decision.
  always_comb begin
    tick_s       = 1'b0;
    cnt_nxt_s    = cnt_r;
    led_on_nxt_s = led_on_r;
    if (cnt_r == CNT_MAX) begin
      tick_s       = 1'b1;
      cnt_nxt_s    = CNT_ZERO;
      led_on_nxt_s = ~led_on_r;
    end else begin
      tick_s       = 1'b0;
      cnt_nxt_s    = cnt_r + CNT_ONE;
      led_on_nxt_s = led_on_r;
    end
  end

  // State registers; the pin has its own flop so nothing combinational follows it.
  always_ff @(posedge USER_CLK) begin
    if (!FPGA_CPU_RESET_B) begin
      cnt_r    <= CNT_ZERO;
      led_on_r <= 1'b0;
      led_n_r  <= 1'b1;
    end else begin
      cnt_r    <= cnt_nxt_s;
      led_on_r <= led_on_nxt_s;
      led_n_r  <= ~led_on_nxt_s;
    end
  end

  assign GPIO_LED_N = led_n_r;

endmodule

// File: tb/tb_blink_led_top.sv
// Directed bench for blink_led_top at HALF_PERIOD=10 plus a HALF_PERIOD=2 corner instance.
// Expected LED levels come from the cycle index since reset release.
module tb_blink_led_top;

  logic clk;
  logic rst_n;
  logic led_n;
  logic led2_n;

  int errors = 0;
  int checks = 0;
  int k = 0;
  int edges = 0;
  int last_edge_k = -1;
  logic prev_led;

  blink_led_top #(.CLK_FREQ_HZ(100), .BLINK_HZ(5)) dut (
    .USER_CLK(clk),
    .FPGA_CPU_RESET_B(rst_n),
    .GPIO_LED_N(led_n)
  );

  blink_led_top #(.CLK_FREQ_HZ(4), .BLINK_HZ(1)) dut_min (
    .USER_CLK(clk),
    .FPGA_CPU_RESET_B(rst_n),
    .GPIO_LED_N(led2_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", tag, obs, exp, k);
    end
  endtask

  function automatic logic exp_led_n(input int cyc, input int half);
    return ((cyc / half) % 2 == 0) ? 1'b1 : 1'b0;
  endfunction

  // Hold reset for n cycles (driven at a falling edge), then release it.
  task automatic do_reset(input int n);
    rst_n = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("reset_hold", {31'd0, led_n}, 32'd1);
      check("reset_hold_min", {31'd0, led2_n}, 32'd1);
    end
    rst_n = 1'b1;
    k = 0;
  endtask

  task automatic run_cycles(input int n, input bit track);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      check("led_n", {31'd0, led_n}, {31'd0, exp_led_n(k, 10)});
      check("led_n_min", {31'd0, led2_n}, {31'd0, exp_led_n(k, 2)});
      if (track && (led_n !== prev_led)) begin
        edges++;
        if (last_edge_k < 0) check("first_edge", k, 32'd10);
        else check("run_len", k - last_edge_k, 32'd10);
        last_edge_k = k;
      end
      prev_led = led_n;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    @(negedge clk);

    // Reset held for 5 cycles, then 1000 free-running cycles with duty tracking
    do_reset(5);
    prev_led = led_n;
    run_cycles(1000, 1'b1);
    check("edge_count", edges, 32'd100);

    // Reset mid-phase at cycle 15 while the LED is lit
    do_reset(1);
    run_cycles(15, 1'b0);
    check("lit_at_15", {31'd0, led_n}, 32'd0);
    do_reset(1);
    run_cycles(10, 1'b0);
    check("relight_10", {31'd0, led_n}, 32'd0);

    // Reset pulse between edges must not affect anything
    run_cycles(2, 1'b0);
    #1 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    #1 check("async_pulse", {31'd0, led_n}, 32'd0);
    run_cycles(10, 1'b0);
    check("after_pulse", {31'd0, led_n}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
